alarm_sequencer: RTL and testbench

Generates the `start` pulses that drive the LED flasher from the lock's code-check results. Each wrong-code event requests one flash burst. Requests that arrive while a burst is still running are queued and issued at a fixed hold-off spacing. Consecutive failures are counted, and reaching the limit puts the lock into a timed lockout.

---
 rtl/alarm_pkg.sv | 15 +
 rtl/lockout_timer.sv | 31 +++
 rtl/alarm_sequencer.sv | 141 ++++++++++++++
 tb/tb_alarm_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm sequencer.
// Used by alarm_sequencer and lockout_timer.
package alarm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } issuer_state_t;

    localparam int DEF_MAX_FAIL       = 3;
    localparam int DEF_HOLDOFF        = 13;
    localparam int DEF_LOCKOUT_CYCLES = 1000;
    localparam int DEF_PEND_W         = 3;

endpackage

// File: rtl/lockout_timer.sv
// Lockout down-counter: a trigger pulse loads LOCKOUT_CYCLES.
// While the count is non-zero, locked is high.
module lockout_timer
    import alarm_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic locked
);

    localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(LOCKOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (trigger) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign locked = (count != '0);

endmodule

// File: rtl/alarm_sequencer.sv
// Turns code-check results into flasher start pulses with hold-off spacing and a failure lockout.
// Build option: define ALARM_LOCKOUT_EN to compile in the lockout timer and failure-limit lockout.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int MAX_FAIL       = DEF_MAX_FAIL,
    parameter int HOLDOFF        = DEF_HOLDOFF,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int PEND_W         = DEF_PEND_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            code_ok,
    input  logic                            code_err,
    output logic                            start,
    output logic                            locked,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(HOLDOFF);
    localparam logic [FW-1:0]     FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [TW-1:0]     HOLD_LOAD = TW'(HOLDOFF - 2);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    if (MAX_FAIL < 1 || HOLDOFF < 2 || LOCKOUT_CYCLES < 1 || PEND_W < 1) begin : g_bad_params
        $error("alarm_sequencer: illegal parameter value");
    end

    logic locked_int;
    logic acc_err;
    logic acc_ok;

    // An error wins over a simultaneous OK; nothing is accepted during lockout.
    assign acc_err = code_err & ~locked_int;
    assign acc_ok  = code_ok & ~code_err & ~locked_int;

    // Issuer: HOLD lasts HOLDOFF-1 cycles so backlogged starts land exactly HOLDOFF apart.
    issuer_state_t     state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              start_q, start_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q != '0 || acc_err) begin
                    start_d = 1'b1;
                    timer_d = HOLD_LOAD;
                    state_d = HOLD;
                    // A new error alongside a pending issue takes the freed slot.
                    if (pend_q != '0 && !acc_err) begin
                        pend_d = pend_q - PEND_W'(1);
                    end
                end
            end
            HOLD: begin
                if (acc_err && pend_q != PEND_MAX) begin
                    pend_d = pend_q + PEND_W'(1);
                end
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
        endcase
    end

    logic [FW-1:0] fail_q;

`ifdef ALARM_LOCKOUT_EN
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);

    logic trigger;

    assign trigger = acc_err && (fail_q == FAIL_LAST);

    // The internal count restarts at 0 on lockout; the output shows the limit until it ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q <= '0;
        end else if (trigger) begin
            fail_q <= '0;
        end else if (acc_err) begin
            fail_q <= fail_q + FW'(1);
        end else if (acc_ok) begin
            fail_q <= '0;
        end
    end

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .locked  (locked_int)
    );

    assign fail_count = locked_int ? FAIL_MAX : fail_q;
`else
    assign locked_int = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q <= '0;
        end else if (acc_err) begin
            if (fail_q != FAIL_MAX) begin
                fail_q <= fail_q + FW'(1);
            end
        end else if (acc_ok) begin
            fail_q <= '0;
        end
    end

    assign fail_count = fail_q;
`endif

    assign start  = start_q;
    assign locked = locked_int;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed table, multi-cycle scenarios, random vs. model.
// Follows ALARM_LOCKOUT_EN the same way the design does.
module tb_alarm_sequencer;

    localparam int MAX_FAIL       = 3;
    localparam int HOLDOFF        = 13;
    localparam int LOCKOUT_CYCLES = 1000;
    localparam int PEND_W         = 3;
    localparam int FW             = $clog2(MAX_FAIL + 1);
    localparam int PMAX           = (1 << PEND_W) - 1;
    localparam int W              = FW + 2;
    localparam int MAX_FAIL_B     = 16;
    localparam int FWB            = $clog2(MAX_FAIL_B + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic code_ok = 1'b0;
    logic code_err = 1'b0;
    logic start, locked;
    logic [FW-1:0] fail_count;
    logic start_b, locked_b;
    logic [FWB-1:0] fail_count_b;

    always #5 clk = ~clk;

    alarm_sequencer #(
        .MAX_FAIL(MAX_FAIL), .HOLDOFF(HOLDOFF),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .PEND_W(PEND_W)
    ) dut (
        .clk(clk), .rst(rst), .code_ok(code_ok), .code_err(code_err),
        .start(start), .locked(locked), .fail_count(fail_count)
    );

    // Second instance with a high failure limit so long error bursts are not cut off by lockout.
    alarm_sequencer #(
        .MAX_FAIL(MAX_FAIL_B), .HOLDOFF(HOLDOFF),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .PEND_W(PEND_W)
    ) dut_b (
        .clk(clk), .rst(rst), .code_ok(code_ok), .code_err(code_err),
        .start(start_b), .locked(locked_b), .fail_count(fail_count_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, m_n);
        end
    endtask

    // ---------------- reference model ----------------
    // Time-based view: a start may appear no earlier than m_next_free; lockout is a cycle window.
    int m_n, m_lock_start, m_lock_end, m_fc, m_pend, m_next_free;
    logic [W-1:0] exp_q[$];

    function automatic bit m_locked_at(input int c);
        return (c > m_lock_start) && (c <= m_lock_end);
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_lock_start = -1;
        m_lock_end = -1;
        m_fc = 0;
        m_pend = 0;
        m_next_free = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit ok, input bit err);
        bit lk, acc_err, acc_ok, issue;
        lk = m_locked_at(m_n);
        acc_err = err && !lk;
        acc_ok = ok && !err && !lk;
        issue = 1'b0;
        if (m_n + 1 >= m_next_free) begin
            if (m_pend > 0) begin
                issue = 1'b1;
                m_pend--;
                if (acc_err) m_pend++;
            end else if (acc_err) begin
                issue = 1'b1;
            end
        end else if (acc_err && m_pend < PMAX) begin
            m_pend++;
        end
        if (issue) m_next_free = m_n + 1 + HOLDOFF;
`ifdef ALARM_LOCKOUT_EN
        if (acc_err) begin
            m_fc++;
            if (m_fc == MAX_FAIL) begin
                m_lock_start = m_n;
                m_lock_end = m_n + LOCKOUT_CYCLES;
                m_fc = 0;
            end
        end else if (acc_ok) begin
            m_fc = 0;
        end
`else
        if (acc_err) begin
            if (m_fc < MAX_FAIL) m_fc++;
        end else if (acc_ok) begin
            m_fc = 0;
        end
`endif
        m_n++;
        lk = m_locked_at(m_n);
        exp_q.push_back({issue, lk, FW'(lk ? MAX_FAIL : m_fc)});
    endtask

    // ---------------- driver tasks ----------------
    int a_starts[$];
    int b_starts[$];
    int lock_first, lock_last;

    task automatic tick(input bit ok, input bit err);
        logic [W-1:0] e;
        code_ok = ok;
        code_err = err;
        model_step(ok, err);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("start", 32'(start), 32'(e[W-1]));
        chk("locked", 32'(locked), 32'(e[W-2]));
        chk("fail_count", 32'(fail_count), 32'(e[FW-1:0]));
        if (start) a_starts.push_back(m_n);
        if (start_b) b_starts.push_back(m_n);
        if (locked) begin
            if (lock_first < 0) lock_first = m_n;
            lock_last = m_n;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        code_ok = 1'b0;
        code_err = 1'b0;
        #1;
        chk("rst_start", 32'(start), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_fail_count", 32'(fail_count), 0);
        chk("rst_start_b", 32'(start_b), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        a_starts.delete();
        b_starts.delete();
        lock_first = -1;
        lock_last = -1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit ok;
        bit err;
        int reps;
        bit s;
        bit l;
        int fc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int exp_starts[$];
        int fc501, fc1013, cnt;

        // Expected outputs are for the cycle after the inputs are sampled.
        tbl[0] = '{0, 1, 1,  1, 0, 1};  // first error issues at once
        tbl[1] = '{0, 0, 1,  0, 0, 1};
        tbl[2] = '{1, 0, 1,  0, 0, 0};  // OK clears the count
        tbl[3] = '{1, 1, 1,  0, 0, 1};  // both high -> error, queued during hold-off
        tbl[4] = '{0, 0, 9,  0, 0, 1};
        tbl[5] = '{0, 0, 1,  1, 0, 1};  // queued start exactly HOLDOFF after the first
        tbl[6] = '{1, 0, 1,  0, 0, 0};
        tbl[7] = '{0, 1, 1,  0, 0, 1};
        tbl[8] = '{0, 0, 10, 0, 0, 1};
        tbl[9] = '{0, 0, 1,  1, 0, 1};

        model_reset();
        lock_first = -1;
        lock_last = -1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                tick(tbl[i].ok, tbl[i].err);
                chk($sformatf("tbl%0d_start", i), 32'(start), 32'(tbl[i].s));
                chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].l));
                chk($sformatf("tbl%0d_fc", i), 32'(fail_count), 32'(tbl[i].fc));
            end
        end

        // Back-to-back errors into lockout, plus an error in the middle of it.
        do_reset();
        repeat (10) tick(1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b1);
        fc501 = -1;
        fc1013 = -1;
        while (m_n < 1015) begin
            tick(1'b0, m_n == 500);
            if (m_n == 501) fc501 = fail_count;
            if (m_n == 1013) fc1013 = fail_count;
        end
`ifdef ALARM_LOCKOUT_EN
        exp_starts = '{11, 24, 37};
        chk("lock_first", 32'(lock_first), 13);
        chk("lock_last", 32'(lock_last), 1012);
        chk("lock_fc_501", 32'(fc501), 3);
        chk("lock_fc_1013", 32'(fc1013), 0);
`else
        exp_starts = '{11, 24, 37, 501};
        chk("nolock_first", 32'(lock_first), 32'(-1));
        chk("nolock_fc_501", 32'(fc501), 3);
        chk("nolock_fc_1013", 32'(fc1013), 3);
`endif
        chk("lock_start_count", 32'(a_starts.size()), 32'(exp_starts.size()));
        for (int i = 0; i < exp_starts.size() && i < a_starts.size(); i++)
            chk($sformatf("lock_start%0d", i), 32'(a_starts[i]), 32'(exp_starts[i]));

        // Pending saturation: ten errors -> eight starts spaced HOLDOFF apart.
        do_reset();
        repeat (2) tick(1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b1);
        repeat (120) tick(1'b0, 1'b0);
        chk("sat_count", 32'(b_starts.size()), 8);
        if (b_starts.size() > 0) chk("sat_first", 32'(b_starts[0]), 3);
        for (int i = 1; i < b_starts.size(); i++)
            chk($sformatf("sat_gap%0d", i), 32'(b_starts[i] - b_starts[i-1]), HOLDOFF);

        // Reset in the middle of the backlog discards everything pending.
        do_reset();
        repeat (2) tick(1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b1);
        cnt = 0;
        while (b_starts.size() < 2 && cnt < 40) begin
            tick(1'b0, 1'b0);
            cnt++;
        end
        chk("midrst_seen_two", 32'(b_starts.size()), 2);
        do_reset();
        repeat (120) tick(1'b0, 1'b0);
        chk("midrst_b_starts", 32'(b_starts.size()), 0);
        chk("midrst_a_starts", 32'(a_starts.size()), 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit ok, err;
            err = ($urandom_range(0, 4) == 0);
            ok = ($urandom_range(0, 7) == 0);
            if ((i / 400) % 2 == 1) err = ($urandom_range(0, 1) == 0);
            tick(ok, err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
